// File: rtl/clk_div_multi_if.sv
// Bundles the per-channel control and status signals of the multi-channel
// clock divider. The slave side is the divider. The master side drives
// enables, the sync strobe and divisor loads.
interface clk_div_multi_if #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 26
);
    logic [N_CH-1:0]       en;
    logic                  sync;
    logic [N_CH-1:0]       load;
    logic [N_CH*WIDTH-1:0] div_in;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       pend;

    modport master (
        output en, sync, load, div_in,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, sync, load, div_in,
        output clk_out, tick, pend
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..k and toggles a 50% square wave at every terminal
// count. A one-cycle tick marks each terminal. A divisor loaded mid-period
// is held pending and takes over only at the next period boundary, so the
// output never produces a runt pulse. A global sync restarts every channel
// from the same phase.
module clk_div_multi #(
    parameter int N_CH        = 2,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 10000000
) (
    input logic            clk,
    input logic            rst,
    clk_div_multi_if.slave bus
);

    localparam logic [WIDTH-1:0] DEFAULT_K = WIDTH'(DEFAULT_DIV);

    // Per-channel state
    logic [WIDTH-1:0] cnt_q     [N_CH];
    logic [WIDTH-1:0] cnt_d     [N_CH];
    logic [WIDTH-1:0] div_act_q [N_CH];
    logic [WIDTH-1:0] div_act_d [N_CH];
    logic [WIDTH-1:0] div_pnd_q [N_CH];
    logic [WIDTH-1:0] div_pnd_d [N_CH];
    logic [N_CH-1:0]  pend_q,    pend_d;
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q,    tick_d;

    // Per-channel decode of the inputs and current count
    logic [WIDTH-1:0] load_val  [N_CH];
    logic [N_CH-1:0]  restart;
    logic [N_CH-1:0]  terminal;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign load_val[g] = bus.div_in[g*WIDTH +: WIDTH];
        // A sync or a disabled channel forces a fresh period from phase zero.
        assign restart[g]  = bus.sync | ~bus.en[g];
        // Equality is enough: cnt never exceeds div_act, because a smaller
        // divisor only becomes active while cnt is being cleared.
        assign terminal[g] = (cnt_q[g] == div_act_q[g]);
    end

    // Next-state for each channel: restart, terminal count, or plain count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every variable gets a default before any branch, so no
            // path leaves one unassigned and no latch is inferred.
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            div_pnd_d[i] = div_pnd_q[i];
            pend_d[i]    = pend_q[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            if (restart[i] || terminal[i]) begin
                // Period boundary: start a new period and switch divisors.
                cnt_d[i]     = '0;
                clk_out_d[i] = restart[i] ? 1'b0 : ~clk_out_q[i];
                tick_d[i]    = ~restart[i];
                // A load landing on the boundary goes straight to the
                // active divisor and beats an older pending value.
                if (bus.load[i]) begin
                    div_act_d[i] = load_val[i];
                end else if (pend_q[i]) begin
                    div_act_d[i] = div_pnd_q[i];
                end
                pend_d[i]    = 1'b0;
            end else begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
                // Mid-period load waits for the boundary; the last one wins.
                if (bus.load[i]) begin
                    div_pnd_d[i] = load_val[i];
                    pend_d[i]    = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are ordinary flops, not RAM, so
            // every element is reset; a reset mid-period leaves no partial pulse.
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= DEFAULT_K;
                div_pnd_q[i] <= '0;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge.
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_pnd_q <= div_pnd_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.pend    = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (2 channels, default divisor 3).
// A reference model runs alongside the DUT for every cycle. It is written
// as a countdown to the next terminal plus an optional queued divisor.
// Hand-derived vector tables and sequences cover the corner cases.
module tb_clk_div_multi;

    localparam int N_CH  = 2;
    localparam int WIDTH = 26;
    localparam int DEF_K = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_div_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    clk_div_multi #(
        .N_CH       (N_CH),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEF_K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles left until the next terminal edge, the active
    // divisor, and at most one queued divisor waiting for a boundary.
    int unsigned m_left     [N_CH];
    int unsigned m_k        [N_CH];
    int unsigned m_next     [N_CH];
    bit          m_has_next [N_CH];
    bit          m_wave     [N_CH];
    bit          m_strobe   [N_CH];

    task automatic model_step();
        for (int c = 0; c < N_CH; c++) begin
            int unsigned d;
            bit restart;
            bit boundary;
            d        = int'(bus.div_in[c*WIDTH +: WIDTH]);
            restart  = bus.sync || !bus.en[c];
            boundary = restart || (m_left[c] == 1);
            if (rst) begin
                m_k[c]        = DEF_K;
                m_left[c]     = DEF_K + 1;
                m_has_next[c] = 1'b0;
                m_wave[c]     = 1'b0;
                m_strobe[c]   = 1'b0;
            end else if (boundary) begin
                if (bus.load[c])        m_k[c] = d;
                else if (m_has_next[c]) m_k[c] = m_next[c];
                m_has_next[c] = 1'b0;
                m_wave[c]     = restart ? 1'b0 : !m_wave[c];
                m_strobe[c]   = !restart;
                m_left[c]     = m_k[c] + 1;
            end else begin
                m_left[c]   = m_left[c] - 1;
                m_strobe[c] = 1'b0;
                if (bus.load[c]) begin
                    m_has_next[c] = 1'b1;
                    m_next[c]     = d;
                end
            end
        end
    endtask

    // One clock: update the model with the inputs in force, wait for the
    // edge, then compare at the falling edge.
    task automatic advance();
        logic [N_CH-1:0] ew, es, ep;
        model_step();
        @(negedge clk);
        for (int c = 0; c < N_CH; c++) begin
            ew[c] = m_wave[c];
            es[c] = m_strobe[c];
            ep[c] = m_has_next[c];
        end
        check("model clk_out", 32'(bus.clk_out), 32'(ew));
        check("model tick",    32'(bus.tick),    32'(es));
        check("model pend",    32'(bus.pend),    32'(ep));
    endtask

    task automatic drive(input logic r, input logic [1:0] e, input logic s,
                         input logic [1:0] l, input int unsigned d0, input int unsigned d1);
        rst        = r;
        bus.en     = e;
        bus.sync   = s;
        bus.load   = l;
        bus.div_in = {WIDTH'(d1), WIDTH'(d0)};
    endtask

    // Count cycles until clk_out[ch] changes, bounded.
    task automatic half_period(input int ch, output int len);
        logic start;
        start = bus.clk_out[ch];
        len   = 0;
        do begin
            advance();
            len++;
        end while (bus.clk_out[ch] === start && len < 20);
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  en;
        logic        sync;
        logic [1:0]  load;
        int unsigned div1;
        logic [1:0]  exp_clk;
        logic [1:0]  exp_tick;
        logic [1:0]  exp_pend;
    } vec_t;

    vec_t tv[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;

        drive(1'b1, 2'b00, 1'b0, 2'b00, 0, 0);

        // Reset with default k=3, then free-run; ch1 picks up k=1 mid-period.
        tv.push_back('{1'b1, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b00});
        tv.push_back('{1'b1, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b11, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b11, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b10, 1, 2'b00, 2'b00, 2'b10});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b10});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b00, 2'b00, 2'b10});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b11, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b11, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b01, 2'b10, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b01, 2'b00, 2'b00});
        tv.push_back('{1'b0, 2'b11, 1'b0, 2'b00, 0, 2'b10, 2'b11, 2'b00});

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].en, tv[i].sync, tv[i].load, 0, tv[i].div1);
            advance();
            check($sformatf("vec%0d clk_out", i), 32'(bus.clk_out), 32'(tv[i].exp_clk));
            check($sformatf("vec%0d tick", i),    32'(bus.tick),    32'(tv[i].exp_tick));
            check($sformatf("vec%0d pend", i),    32'(bus.pend),    32'(tv[i].exp_pend));
        end

        // k=0 on ch0: toggles every cycle, tick held high.
        drive(1'b0, 2'b00, 1'b0, 2'b01, 0, 0);
        advance();
        check("k0 idle clk_out", 32'(bus.clk_out[0]), 32'(0));
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 8; j++) begin
            advance();
            check("k0 clk_out", 32'(bus.clk_out[0]), (j % 2 == 0) ? 32'(1) : 32'(0));
            check("k0 tick",    32'(bus.tick[0]),    32'(1));
        end

        // k=9 with a k=2 load at cnt=4: pending until the terminal.
        drive(1'b0, 2'b00, 1'b0, 2'b01, 9, 0);
        advance();
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 4; j++) advance();
        drive(1'b0, 2'b01, 1'b0, 2'b01, 2, 0);
        advance();
        check("k9 pend after load", 32'(bus.pend[0]), 32'(1));
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 4; j++) begin
            advance();
            check("k9 pend held", 32'(bus.pend[0]), 32'(1));
            check("k9 no early toggle", 32'(bus.clk_out[0]), 32'(0));
        end
        advance();
        check("k9 terminal pend", 32'(bus.pend[0]),    32'(0));
        check("k9 terminal tick", 32'(bus.tick[0]),    32'(1));
        check("k9 terminal clk",  32'(bus.clk_out[0]), 32'(1));
        half_period(0, len);
        check("k2 half-period a", 32'(len), 32'(3));
        half_period(0, len);
        check("k2 half-period b", 32'(len), 32'(3));

        // Load coincident with terminal (k 5 -> 1): pend never asserts.
        drive(1'b0, 2'b00, 1'b0, 2'b01, 5, 0);
        advance();
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 5; j++) begin
            advance();
            check("k5 counting tick", 32'(bus.tick[0]), 32'(0));
        end
        drive(1'b0, 2'b01, 1'b0, 2'b01, 1, 0);
        advance();
        check("coincident pend", 32'(bus.pend[0]),    32'(0));
        check("coincident tick", 32'(bus.tick[0]),    32'(1));
        check("coincident clk",  32'(bus.clk_out[0]), 32'(1));
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        half_period(0, len);
        check("k1 half-period", 32'(len), 32'(2));
        check("k1 pend still low", 32'(bus.pend[0]), 32'(0));

        // Two k=3 channels started 2 cycles apart, then realigned by sync.
        drive(1'b0, 2'b00, 1'b0, 2'b11, 3, 3);
        advance();
        drive(1'b0, 2'b01, 1'b0, 2'b00, 0, 0);
        advance();
        advance();
        drive(1'b0, 2'b11, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 3; j++) advance();
        drive(1'b0, 2'b11, 1'b1, 2'b00, 0, 0);
        advance();
        check("sync clk_out", 32'(bus.clk_out), 32'(0));
        check("sync tick",    32'(bus.tick),    32'(0));
        drive(1'b0, 2'b11, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 12; j++) begin
            advance();
            check("aligned tick", 32'(bus.tick), (j % 4 == 3) ? 32'(3) : 32'(0));
            check("aligned clk",  32'(bus.clk_out), (((j + 1) / 4) % 2 == 1) ? 32'(3) : 32'(0));
        end

        // Drop ch0 enable mid-period for 5 cycles, then raise it.
        advance();
        advance();
        drive(1'b0, 2'b10, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 5; j++) begin
            advance();
            check("disabled clk_out", 32'(bus.clk_out[0]), 32'(0));
            check("disabled tick",    32'(bus.tick[0]),    32'(0));
        end
        drive(1'b0, 2'b11, 1'b0, 2'b00, 0, 0);
        for (int j = 0; j < 4; j++) begin
            advance();
            check("re-enable tick", 32'(bus.tick[0]), (j == 3) ? 32'(1) : 32'(0));
        end

        // Reset mid-period with a pending load outstanding.
        drive(1'b0, 2'b11, 1'b0, 2'b11, 6, 6);
        advance();
        drive(1'b1, 2'b11, 1'b0, 2'b00, 0, 0);
        advance();
        check("mid rst clk_out", 32'(bus.clk_out), 32'(0));
        check("mid rst tick",    32'(bus.tick),    32'(0));
        check("mid rst pend",    32'(bus.pend),    32'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 199) == 0),
                  {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)},
                  ($urandom_range(0, 39) == 0),
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                  $urandom_range(0, 7), $urandom_range(0, 7));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
